// File: rtl/lpddr5x_dma_initiator_if.sv
// Bundles the descriptor, write/read stream and controller cmd/rsp signals of lpddr5x_dma_initiator.
// Signal names keep the initiator's original port names; master is the initiator side.
interface lpddr5x_dma_initiator_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 16
);
  logic                  desc_valid_i;
  logic                  desc_ready_o;
  logic [ADDR_WIDTH-1:0] desc_addr_i;
  logic [LEN_WIDTH-1:0]  desc_len_i;
  logic                  desc_write_i;
  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  rd_valid_o;
  logic                  rd_ready_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  mem_cmd_valid_o;
  logic                  mem_cmd_ready_i;
  logic [ADDR_WIDTH-1:0] mem_cmd_addr_o;
  logic [DATA_WIDTH-1:0] mem_cmd_wdata_o;
  logic                  mem_cmd_write_o;
  logic                  mem_rsp_valid_i;
  logic [DATA_WIDTH-1:0] mem_rsp_rdata_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;

  modport master (
    input  desc_valid_i, desc_addr_i, desc_len_i, desc_write_i,
    input  wr_valid_i, wr_data_i, rd_ready_i,
    input  mem_cmd_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i,
    output desc_ready_o, wr_ready_o, rd_valid_o, rd_data_o,
    output mem_cmd_valid_o, mem_cmd_addr_o, mem_cmd_wdata_o, mem_cmd_write_o,
    output busy_o, done_o, err_o
  );

  modport slave (
    output desc_valid_i, desc_addr_i, desc_len_i, desc_write_i,
    output wr_valid_i, wr_data_i, rd_ready_i,
    output mem_cmd_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i,
    input  desc_ready_o, wr_ready_o, rd_valid_o, rd_data_o,
    input  mem_cmd_valid_o, mem_cmd_addr_o, mem_cmd_wdata_o, mem_cmd_write_o,
    input  busy_o, done_o, err_o
  );
endinterface

// File: rtl/lpddr5x_dma_initiator.sv
// Descriptor-driven requester: turns {addr, len, dir} into single-beat controller commands,
// with a credit-protected read FIFO so stall-free controller responses are never lost.
module lpddr5x_dma_initiator #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 512,
  parameter int LEN_WIDTH     = 16,
  parameter int RD_FIFO_DEPTH = 8,
  parameter int BEAT_STRIDE   = 4
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  lpddr5x_dma_initiator_if.master bus
);
  localparam int unsigned PW = $clog2(RD_FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(RD_FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remain_q;
  logic [CW-1:0]         outst_q;
  logic [CW-1:0]         count_q;
  logic [PW-1:0]         wptr_q;
  logic [PW-1:0]         rptr_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] fifo_mem [RD_FIFO_DEPTH];

  logic          desc_hs;
  logic          cmd_valid;
  logic          cmd_hs;
  logic          rd_cmd_hs;
  logic          last_beat;
  logic          rsp_take;
  logic          rsp_drop;
  logic          pop;
  logic [CW:0]   inflight;

  assign desc_hs   = (state_q == S_IDLE) && bus.desc_valid_i;
  // Credits cover both buffered beats and responses still owed by the controller.
  assign inflight  = {1'b0, count_q} + {1'b0, outst_q};
  assign cmd_hs    = cmd_valid && bus.mem_cmd_ready_i;
  assign rd_cmd_hs = cmd_hs && (state_q == S_READ);
  assign last_beat = (remain_q == LEN_WIDTH'(1));
  assign rsp_take  = bus.mem_rsp_valid_i && (outst_q != '0);
  assign rsp_drop  = bus.mem_rsp_valid_i && (outst_q == '0);
  assign pop       = (count_q != '0) && bus.rd_ready_i;

  always_comb begin
    cmd_valid = 1'b0;
    if (state_q == S_WRITE) begin
      cmd_valid = bus.wr_valid_i;
    end else if (state_q == S_READ) begin
      cmd_valid = (inflight < DEPTH_C);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (desc_hs) begin
          if (bus.desc_len_i == '0) begin
            state_d = S_DONE;
          end else if (bus.desc_write_i) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_WRITE: if (cmd_hs && last_beat) state_d = S_DONE;
      S_READ:  if (cmd_hs && last_beat) state_d = S_DRAIN;
      S_DRAIN: if ((outst_q == '0) && (count_q == '0)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      outst_q  <= '0;
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (desc_hs) begin
        addr_q   <= bus.desc_addr_i;
        remain_q <= bus.desc_len_i;
      end else if (cmd_hs) begin
        addr_q   <= addr_q + ADDR_WIDTH'(BEAT_STRIDE);
        remain_q <= remain_q - LEN_WIDTH'(1);
      end
      if (rd_cmd_hs && !rsp_take) begin
        outst_q <= outst_q + CW'(1);
      end else if (rsp_take && !rd_cmd_hs) begin
        outst_q <= outst_q - CW'(1);
      end
      if (rsp_take) wptr_q <= wptr_q + PW'(1);
      if (pop)      rptr_q <= rptr_q + PW'(1);
      if (rsp_take && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !rsp_take) begin
        count_q <= count_q - CW'(1);
      end
      if (desc_hs) begin
        err_q <= 1'b0;
      end else if (rsp_drop && ((state_q == S_READ) || (state_q == S_DRAIN))) begin
        err_q <= 1'b1;
      end
    end
  end

  // Storage is not reset; occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (rsp_take) fifo_mem[wptr_q] <= bus.mem_rsp_rdata_i;
  end

  assign bus.desc_ready_o    = (state_q == S_IDLE);
  assign bus.wr_ready_o      = (state_q == S_WRITE) && bus.mem_cmd_ready_i;
  assign bus.rd_valid_o      = (count_q != '0);
  assign bus.rd_data_o       = fifo_mem[rptr_q];
  assign bus.mem_cmd_valid_o = cmd_valid;
  assign bus.mem_cmd_addr_o  = addr_q;
  assign bus.mem_cmd_wdata_o = bus.wr_data_i;
  assign bus.mem_cmd_write_o = (state_q == S_WRITE);
  assign bus.busy_o          = (state_q != S_IDLE);
  assign bus.done_o          = (state_q == S_DONE);
  assign bus.err_o           = err_q;
endmodule
